// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

    localparam int MAX_N = 8;

    // Width of a counter that must hold values 0..timeout inclusive.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin sharing of one UART transmitter between N requesters.
//
// state  | meaning
// IDLE   | no owner; arbitrate among pending requests
// SEND   | owner holds grant; accept its byte once transmitter is free
// SETTLE | one cycle for the transmitter to raise tx_busy
// DRAIN  | wait for tx_busy low, then end packet or return to SEND
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk_50m,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] req_din,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           wr_en,
    output logic [7:0]     din,
    input  logic           tx_busy
);

    localparam int IW = $clog2(N);
    localparam int CW = cnt_width(TIMEOUT);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [N-1:0]  grant_nxt, ack_nxt;
    logic          wr_en_nxt;
    logic [7:0]    din_nxt;
    logic          last_q, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          pick_valid;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state  <= ST_IDLE;
            ptr    <= IW'(N - 1);
            grant  <= '0;
            ack    <= '0;
            wr_en  <= 1'b0;
            din    <= '0;
            last_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            grant  <= grant_nxt;
            ack    <= ack_nxt;
            wr_en  <= wr_en_nxt;
            din    <= din_nxt;
            last_q <= last_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // ptr doubles as the owner index while a grant is held.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        ack_nxt   = '0;
        wr_en_nxt = 1'b0;
        din_nxt   = din;
        last_nxt  = last_q;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (pick_valid) begin
                    grant_nxt = pick_onehot;
                    ptr_nxt   = pick_idx;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (req[ptr]) begin
                    if (!tx_busy) begin
                        din_nxt   = req_din[{ptr, 3'b000} +: 8];
                        last_nxt  = req_last[ptr];
                        wr_en_nxt = 1'b1;
                        ack_nxt   = grant;
                        cnt_nxt   = '0;
                        state_nxt = ST_SETTLE;
                    end
                end else if (cnt == CW'(TIMEOUT)) begin
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SETTLE: state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_nxt = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_SEND;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: arbitration-order table, hand-written corner sequences, randomized packets.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 10;

    logic          clk_50m = 1'b0;
    logic          rst;
    logic [NR-1:0] req, req_last, ack, grant;
    logic [8*NR-1:0] req_din;
    logic          wr_en;
    logic [7:0]    din;
    logic          tx_busy;

    always #5 clk_50m = ~clk_50m;

    uart_tx_arbiter #(.N(NR), .TIMEOUT(TO)) dut (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .req      (req),
        .req_din  (req_din),
        .req_last (req_last),
        .ack      (ack),
        .grant    (grant),
        .wr_en    (wr_en),
        .din      (din),
        .tx_busy  (tx_busy)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester byte queues: {last, data}.
    logic [8:0] pq [NR][$];
    int         ev_idx[$];
    int         ev_din[$];
    int         ev_cyc[$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         busy_len = 3;
    bit         rand_busy = 0;
    bit         force_busy = 0;
    int         busy_fall_cyc = -1;
    int         grant_fall_cyc = -1;
    int         busy_viol = 0;
    int         ack_bad = 0;
    logic [NR-1:0] grant_prev = '0;

    // Monitor, transmitter model and client drivers, all on the falling edge.
    initial begin
        req = '0; req_din = '0; req_last = '0; tx_busy = 1'b0;
        forever begin
            @(negedge clk_50m);
            cyc++;
            if (wr_en) begin
                int w;
                w = -1;
                for (int i = 0; i < NR; i++) if (ack[i]) w = i;
                if (tx_busy) busy_viol++;
                if (ack != grant || $countones(grant) != 1) ack_bad++;
                ev_idx.push_back(w);
                ev_din.push_back(int'(din));
                ev_cyc.push_back(cyc);
            end else if (ack != '0) begin
                ack_bad++;
            end
            if (grant_prev != '0 && grant == '0) grant_fall_cyc = cyc;
            grant_prev = grant;

            if (wr_en) busy_cnt = rand_busy ? int'($urandom_range(0, 6)) : busy_len;
            else if (busy_cnt > 0) busy_cnt--;
            if (tx_busy && !(busy_cnt != 0 || force_busy)) busy_fall_cyc = cyc;
            tx_busy = (busy_cnt != 0) || force_busy;

            for (int i = 0; i < NR; i++) begin
                if (ack[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                req[i] = (pq[i].size() > 0);
                req_din[8*i +: 8] = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
                req_last[i] = (pq[i].size() > 0) ? pq[i][0][8] : 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_50m);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    function automatic int ev_at_idx(input int k);
        return (k < ev_idx.size()) ? ev_idx[k] : -1;
    endfunction

    function automatic int ev_at_din(input int k);
        return (k < ev_din.size()) ? ev_din[k] : -1;
    endfunction

    function automatic int ev_at_cyc(input int k);
        return (k < ev_cyc.size()) ? ev_cyc[k] : -1;
    endfunction

    task automatic wait_events(input int n, input int budget);
        int c;
        c = 0;
        while (ev_idx.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (ev_idx.size() < n) chk("wait_events_timeout", ev_idx.size(), n);
    endtask

    function automatic bit quiet();
        bit q;
        q = (grant == '0) && !tx_busy && !wr_en;
        for (int i = 0; i < NR; i++) if (pq[i].size() != 0) q = 0;
        return q;
    endfunction

    task automatic wait_quiet(input int budget);
        int c;
        c = 0;
        while (!quiet() && c < budget) begin
            tick(1);
            c++;
        end
        if (!quiet()) begin
            checks++;
            errors++;
            $display("FAIL wait_quiet_timeout actual=grant %b busy %0d required=idle", grant, tx_busy);
        end
    endtask

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] ord;
    } vec_t;

    vec_t vecs [7];

    task automatic run_random(input int round);
        logic [8:0] src [NR][$];
        int exp_i[$];
        int exp_d[$];
        int p, i, base, total;
        logic [8:0] b;
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        rand_busy = 1;
        total = 0;
        for (int r = 0; r < NR; r++) begin
            int npk;
            npk = int'($urandom_range(0, 3));
            for (int k = 0; k < npk; k++) begin
                int len;
                len = int'($urandom_range(1, 3));
                for (int j = 0; j < len; j++) begin
                    b = {(j == len - 1), 8'($urandom_range(0, 255))};
                    src[r].push_back(b);
                    pq[r].push_back(b);
                    total++;
                end
            end
        end
        // Reference: whole packets served in round-robin order starting after N-1.
        p = NR - 1;
        while (exp_i.size() < total) begin
            for (int k = 1; k <= NR; k++) begin
                i = (p + k) % NR;
                if (src[i].size() > 0) begin
                    do begin
                        b = src[i].pop_front();
                        exp_i.push_back(i);
                        exp_d.push_back(int'(b[7:0]));
                    end while (!b[8]);
                    p = i;
                    break;
                end
            end
        end
        base = ev_idx.size();
        wait_events(base + total, 40 * total + 50);
        for (int k = 0; k < total; k++) begin
            chk($sformatf("rand%0d_idx%0d", round, k), ev_at_idx(base + k), exp_i[k]);
            chk($sformatf("rand%0d_din%0d", round, k), ev_at_din(base + k), exp_d[k]);
        end
        wait_quiet(200);
        rand_busy = 0;
    endtask

    initial begin
        int base;
        vecs[0] = '{4'b1111, 3'd4, 8'b11_10_01_00};
        vecs[1] = '{4'b1100, 3'd2, 8'b00_00_11_10};
        vecs[2] = '{4'b0110, 3'd2, 8'b00_00_10_01};
        vecs[3] = '{4'b1011, 3'd3, 8'b00_01_00_11};
        vecs[4] = '{4'b0101, 3'd2, 8'b00_00_00_10};
        vecs[5] = '{4'b0001, 3'd1, 8'b00_00_00_00};
        vecs[6] = '{4'b1001, 3'd2, 8'b00_00_00_11};

        rst = 1'b1;
        tick(3);
        chk("reset_grant", int'(grant), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_din", int'(din), 0);
        rst = 1'b0;
        tick(1);

        // Arbitration order table; pointer carries over between entries.
        busy_len = 3;
        for (int v = 0; v < 7; v++) begin
            base = ev_idx.size();
            for (int i = 0; i < NR; i++)
                if (vecs[v].mask[i]) pq[i].push_back({1'b1, 4'(v), 4'(i)});
            wait_events(base + int'(vecs[v].n), 400);
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                chk($sformatf("vec%0d_idx%0d", v, k), ev_at_idx(base + k), int'(vecs[v].ord[k]));
                chk($sformatf("vec%0d_din%0d", v, k), ev_at_din(base + k), (v << 4) | int'(vecs[v].ord[k]));
            end
            wait_quiet(400);
        end

        // Three-byte packet from requester 0, 20-cycle busy.
        busy_len = 20;
        base = ev_idx.size();
        pq[0].push_back({1'b0, 8'h41});
        pq[0].push_back({1'b0, 8'h42});
        pq[0].push_back({1'b1, 8'h43});
        wait_events(base + 3, 500);
        chk("pkt3_din0", ev_at_din(base), 'h41);
        chk("pkt3_din1", ev_at_din(base + 1), 'h42);
        chk("pkt3_din2", ev_at_din(base + 2), 'h43);
        chk("pkt3_idx2", ev_at_idx(base + 2), 0);
        wait_quiet(200);
        chk("pkt3_count", ev_idx.size() - base, 3);
        chk("pkt3_grant_drop", grant_fall_cyc - busy_fall_cyc, 1);

        // No preemption: requester 0 waits behind requester 1's packet.
        busy_len = 5;
        base = ev_idx.size();
        pq[1].push_back({1'b0, 8'h11});
        pq[1].push_back({1'b0, 8'h12});
        pq[1].push_back({1'b1, 8'h13});
        wait_events(base + 1, 100);
        pq[0].push_back({1'b1, 8'h01});
        wait_events(base + 4, 300);
        chk("nopre_idx1", ev_at_idx(base + 1), 1);
        chk("nopre_idx2", ev_at_idx(base + 2), 1);
        chk("nopre_idx3", ev_at_idx(base + 3), 0);
        chk("nopre_din3", ev_at_din(base + 3), 'h01);
        wait_quiet(200);

        // Timeout: requester 1 goes silent mid-packet, requester 2 waits.
        busy_len = 20;
        base = ev_idx.size();
        pq[1].push_back({1'b0, 8'h21});
        wait_events(base + 1, 100);
        pq[2].push_back({1'b1, 8'h22});
        wait_events(base + 2, 300);
        chk("timeout_grant_drop", grant_fall_cyc - busy_fall_cyc, TO + 2);
        chk("timeout_next_idx", ev_at_idx(base + 1), 2);
        chk("timeout_next_lat", ev_at_cyc(base + 1) - grant_fall_cyc, 2);
        wait_quiet(200);

        // Reset while draining a busy byte.
        base = ev_idx.size();
        pq[0].push_back({1'b0, 8'h31});
        pq[0].push_back({1'b1, 8'h32});
        wait_events(base + 1, 100);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_din", int'(din), 0);
        rst = 1'b0;
        tick(2);
        chk("midrst_regrant", int'(grant), 1);
        wait_events(base + 2, 200);
        chk("midrst_wr_after_busy", ev_at_cyc(base + 1) - busy_fall_cyc, 1);
        chk("midrst_din2", ev_at_din(base + 1), 'h32);
        wait_quiet(200);

        // Transmitter already busy when the grant is issued.
        force_busy = 1;
        tick(2);
        base = ev_idx.size();
        pq[3].push_back({1'b1, 8'h5A});
        tick(15);
        chk("prebusy_no_wr", ev_idx.size() - base, 0);
        chk("prebusy_grant", int'(grant), 8);
        force_busy = 0;
        wait_events(base + 1, 100);
        chk("prebusy_wr_lat", ev_at_cyc(base) - busy_fall_cyc, 1);
        chk("prebusy_din", ev_at_din(base), 'h5A);
        wait_quiet(200);

        for (int r = 0; r < 3; r++) run_random(r);

        chk("wr_en_while_busy", busy_viol, 0);
        chk("ack_owner_only", ack_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter (`wr_en`/`din`/`tx_busy` interface) between N requesters with packet-level round-robin arbitration. A requester that wins keeps the transmitter until it sends a byte marked `last`, or until it stalls past a timeout. The block sits between client logic and the transmitter input in the `clk_50m` domain. It only paces writes against `tx_busy` and never touches baud timing.

## Interface
- `N`, 4: number of requesters (2–8).
- `TIMEOUT`, 255: cycles a granted requester may hold `req` low in SEND before its grant is revoked (≥1).
- `clk_50m`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester byte-valid; data must hold stable until `ack`.
- `req_din`  in  8N  byte of requester i at bits [8i+7:8i].
- `req_last`  in  N  byte of requester i ends its packet.
- `ack`  out  N  one-cycle pulse: byte of requester i accepted.
- `grant`  out  N  one-hot current owner; all zero when idle.
- `wr_en`  out  1  one-cycle write strobe to transmitter.
- `din`  out  8  byte to transmitter, valid while `wr_en`=1.
- `tx_busy`  in  1  transmitter busy.

## Operation
- States: IDLE, SEND, SETTLE, DRAIN (enum in package).
- IDLE: if `req`≠0, pick the first requester with `req` set, scanning from `ptr+1` modulo N. Register `grant`, set `ptr` to the winner, and go to SEND. The timeout counter clears.
- SEND, owner g:
  - If `req[g]` and !`tx_busy`: capture `req_din[g]` and `req_last[g]`, pulse `wr_en` and `ack[g]`, then go to SETTLE.
  - If `req[g]`=0: the counter increments. When it reaches `TIMEOUT`, clear `grant` and go to IDLE; `ptr` stays at g.
  - The counter clears on every accepted byte.
- SETTLE: one cycle so the transmitter's `tx_busy` becomes visible. Always go to DRAIN.
- DRAIN: wait for `tx_busy`=0. Then go to IDLE (clearing `grant`) if the captured last=1; otherwise return to SEND.
- `req` from non-owners is ignored until the owner releases. No preemption.
- Only `ack` of the owner can ever assert. `ack` and `wr_en` are never asserted outside the SEND→SETTLE edge.
- Reset values: state IDLE, `ptr`=N-1 (requester 0 wins first), `grant`=0, `ack`=0, `wr_en`=0, `din`=0, counter 0.
- Reset mid-packet: the grant is dropped and the in-flight transmitter byte completes untouched. A new write is issued only after SEND sees `tx_busy`=0, so there is no collision.
- Simultaneous requests in IDLE: resolved purely by round-robin order from `ptr`.
- Requester releasing and re-requesting: it competes again, ranked last behind others.

## Timing
- All outputs are registered.
- Accept cycle: at edge T, SEND sees `req[g]`=1 and `tx_busy`=0. At T+1, `wr_en`=1, `din`=byte, `ack[g]`=1, and state is SETTLE. State is DRAIN at T+2.
- Requester may change `req_din`/`req_last` from the cycle after `ack`.
- Grant latency: `req` seen in IDLE at edge T → `grant` valid at T+1 → earliest `wr_en` at T+2.
- Back-to-back bytes: the next `wr_en` comes 2 cycles after DRAIN sees `tx_busy` fall, at best.
- Packet end: `grant` drops 1 cycle after DRAIN sees `tx_busy`=0. The next arbitration happens on the following cycle.
- Timeout: with `req[g]` low continuously from SEND entry, `grant` clears `TIMEOUT`+1 cycles after SEND entry.

## Structure
- Package `uart_arb_pkg`: state enum, `MAX_N`=8, and a counter width function (clog2 of `TIMEOUT`+1).
- Sub-module `rr_pick`: combinational round-robin pick taking `req` and `ptr` and returning a one-hot winner plus an index. It is reused for any future shared UART receive steering.
- Top module: FSM, data capture, timeout counter.

## Test plan
- Single requester 0 sends a 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), with the transmitter model holding busy 20 cycles per byte. Required:
  - exactly 3 `wr_en` pulses with `din` in that order;
  - `ack[0]` coincident with each pulse;
  - `grant` cleared 1 cycle after the final busy falls.
- All 4 requesting 1-byte packets from reset → service order 0,1,2,3. Then with 2 and 3 requesting again, order is 2,3.
- Requester 1 owns mid-packet while requester 0 asserts `req` → no `ack[0]` until requester 1's last byte completes. Then requester 0 is granted next.
- Owner drops `req` after byte 1 with `TIMEOUT`=10 → `grant` clears exactly 11 cycles after SEND entry. No `wr_en` occurs meanwhile, and the next requester is then granted.
- Assert `rst` for 1 cycle while `tx_busy`=1 in DRAIN → all outputs 0 next cycle. A pending requester is granted afterwards, but its `wr_en` is held until `tx_busy`=0.
- Transmitter busy already high when the grant is issued → no `wr_en` until busy falls. Verify `wr_en` is never asserted while `tx_busy`=1.
